// File: rtl/blinky_mc.sv
`timescale 1ns/1ps
// Multi-channel LED blinker: one staging register feeds NCH independent
// channels, each holding OFF / ON / BLINK / BURST behaviour.

module blinky_mc_ch #(
    parameter int PW = 16,
    parameter int BW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          apply_i,
    input  logic [1:0]    mode_i,
    input  logic [PW-1:0] period_i,
    input  logic [PW-1:0] duty_i,
    input  logic [BW-1:0] burst_i,
    output logic          blinky_o,
    output logic          done_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SOLID = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic          r_burst_mode;
    logic [PW-1:0] r_period;
    logic [PW-1:0] r_duty;
    logic [BW-1:0] r_nburst;
    logic [PW-1:0] r_cnt;
    logic [BW-1:0] r_bcnt;
    logic          r_blinky;
    logic          r_done;

    logic          w_wrap;
    logic [PW-1:0] w_cnt_nxt;
    logic [BW-1:0] w_bcnt_nxt;
    logic          w_last;

    assign w_wrap     = (r_cnt == r_period);
    assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
    assign w_bcnt_nxt = r_bcnt + 1'b1;
    assign w_last     = r_burst_mode && w_wrap && (w_bcnt_nxt == r_nburst);

    // Apply takes priority over run progress, so a config landing on the
    // burst-completion edge suppresses that done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_burst_mode <= 1'b0;
            r_period     <= '0;
            r_duty       <= '0;
            r_nburst     <= '0;
            r_cnt        <= '0;
            r_bcnt       <= '0;
            r_blinky     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (apply_i) begin
                r_burst_mode <= (mode_i == 2'b11);
                r_period     <= period_i;
                r_duty       <= duty_i;
                r_nburst     <= burst_i;
                r_cnt        <= '0;
                r_bcnt       <= '0;
                case (mode_i)
                    2'b00: begin
                        r_state  <= S_IDLE;
                        r_blinky <= 1'b0;
                    end
                    2'b01: begin
                        r_state  <= S_SOLID;
                        r_blinky <= 1'b1;
                    end
                    2'b10: begin
                        r_state  <= S_RUN;
                        r_blinky <= (duty_i != '0);
                    end
                    2'b11: begin
                        if (burst_i == '0) begin
                            r_state  <= S_DONE;
                            r_blinky <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_state  <= S_RUN;
                            r_blinky <= (duty_i != '0);
                        end
                    end
                endcase
            end else if (r_state == S_RUN && en_i) begin
                r_cnt <= w_cnt_nxt;
                if (r_burst_mode && w_wrap)
                    r_bcnt <= w_bcnt_nxt;
                if (w_last) begin
                    r_state  <= S_DONE;
                    r_blinky <= 1'b0;
                    r_done   <= 1'b1;
                end else begin
                    r_blinky <= (w_cnt_nxt < r_duty);
                end
            end
        end
    end

    assign blinky_o = r_blinky;
    assign done_o   = r_done;
endmodule

module blinky_mc #(
    parameter int NCH = 4,
    parameter int PW  = 16,
    parameter int BW  = 8,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           en_i,
    input  logic           cfg_valid_i,
    output logic           cfg_ready_o,
    input  logic [CW-1:0]  cfg_ch_i,
    input  logic [1:0]     cfg_mode_i,
    input  logic [PW-1:0]  cfg_period_i,
    input  logic [PW-1:0]  cfg_duty_i,
    input  logic [BW-1:0]  cfg_burst_i,
    output logic [NCH-1:0] blinky_o,
    output logic [NCH-1:0] done_o
);
    logic          r_stg_vld;
    logic [CW-1:0] r_stg_ch;
    logic [1:0]    r_stg_mode;
    logic [PW-1:0] r_stg_period;
    logic [PW-1:0] r_stg_duty;
    logic [BW-1:0] r_stg_burst;

    assign cfg_ready_o = ~r_stg_vld;

    // Staging holds one config for exactly one cycle; ready drops meanwhile.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stg_vld    <= 1'b0;
            r_stg_ch     <= '0;
            r_stg_mode   <= '0;
            r_stg_period <= '0;
            r_stg_duty   <= '0;
            r_stg_burst  <= '0;
        end else if (cfg_valid_i && !r_stg_vld) begin
            r_stg_vld    <= 1'b1;
            r_stg_ch     <= cfg_ch_i;
            r_stg_mode   <= cfg_mode_i;
            r_stg_period <= cfg_period_i;
            r_stg_duty   <= cfg_duty_i;
            r_stg_burst  <= cfg_burst_i;
        end else begin
            r_stg_vld    <= 1'b0;
        end
    end

    // Channel numbers at or above NCH match no instance and are dropped.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic w_apply;
        assign w_apply = r_stg_vld && (r_stg_ch == CW'(g));

        blinky_mc_ch #(.PW(PW), .BW(BW)) u_ch (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .en_i     (en_i),
            .apply_i  (w_apply),
            .mode_i   (r_stg_mode),
            .period_i (r_stg_period),
            .duty_i   (r_stg_duty),
            .burst_i  (r_stg_burst),
            .blinky_o (blinky_o[g]),
            .done_o   (done_o[g])
        );
    end
endmodule

// File: tb/tb_blinky_mc.sv
`timescale 1ns/1ps
// Bench for blinky_mc: a 4-channel and a 3-channel instance share one config
// bus; a time-since-apply reference model predicts every output each cycle.

module tb_blinky_mc;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic       en_i = 1'b1;
    logic       cfg_valid_i = 1'b0;
    logic [1:0] cfg_ch_i = '0;
    logic [1:0] cfg_mode_i = '0;
    logic [7:0] cfg_period_i = '0;
    logic [7:0] cfg_duty_i = '0;
    logic [7:0] cfg_burst_i = '0;
    logic       rdy4, rdy3;
    logic [3:0] blk4, done4;
    logic [2:0] blk3, done3;

    always #5 clk_i = ~clk_i;

    blinky_mc #(.NCH(4), .PW(8), .BW(8)) u_dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(rdy4), .cfg_ch_i(cfg_ch_i),
        .cfg_mode_i(cfg_mode_i), .cfg_period_i(cfg_period_i),
        .cfg_duty_i(cfg_duty_i), .cfg_burst_i(cfg_burst_i),
        .blinky_o(blk4), .done_o(done4)
    );

    blinky_mc #(.NCH(3), .PW(8), .BW(8)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(rdy3), .cfg_ch_i(cfg_ch_i),
        .cfg_mode_i(cfg_mode_i), .cfg_period_i(cfg_period_i),
        .cfg_duty_i(cfg_duty_i), .cfg_burst_i(cfg_burst_i),
        .blinky_o(blk3), .done_o(done3)
    );

    // Model: per channel the mode, P, D, N and t = enabled cycles since apply.
    int     m_mode [2][4];
    longint m_p [2][4], m_d [2][4], m_n [2][4], m_t [2][4];
    bit     e_done [2][4];
    bit     m_pend;
    int     m_pch, m_pmode;
    longint m_pp, m_pd, m_pn;
    int     n_cmp = 0;
    int     n_mis = 0;

    function automatic bit out_of(int u, int c);
        longint len;
        len = m_n[u][c] * (m_p[u][c] + 1);
        case (m_mode[u][c])
            1:       return 1'b1;
            2:       return (m_t[u][c] % (m_p[u][c] + 1)) < m_d[u][c];
            3:       return (m_t[u][c] < len) && ((m_t[u][c] % (m_p[u][c] + 1)) < m_d[u][c]);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 4; c++) begin
                m_mode[u][c] = 0; m_t[u][c] = 0; e_done[u][c] = 1'b0;
                m_p[u][c] = 0; m_d[u][c] = 0; m_n[u][c] = 0;
            end
        m_pend = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int ch, input int mode,
                              input longint p, input longint d, input longint n, input bit en);
        bit old;
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 4; c++) begin
                longint len;
                bit running;
                e_done[u][c] = 1'b0;
                len = m_n[u][c] * (m_p[u][c] + 1);
                running = (m_mode[u][c] == 2) || (m_mode[u][c] == 3 && m_t[u][c] < len);
                if (running && en) begin
                    m_t[u][c]++;
                    if (m_mode[u][c] == 3 && m_t[u][c] == len) e_done[u][c] = 1'b1;
                end
            end
        old = m_pend;
        if (old)
            for (int u = 0; u < 2; u++)
                if (m_pch < ((u == 0) ? 4 : 3)) begin
                    m_mode[u][m_pch] = m_pmode; m_p[u][m_pch] = m_pp;
                    m_d[u][m_pch] = m_pd; m_n[u][m_pch] = m_pn; m_t[u][m_pch] = 0;
                    e_done[u][m_pch] = (m_pmode == 3) && (m_pn == 0);
                end
        m_pend = 1'b0;
        if (v && !old) begin
            m_pend = 1'b1; m_pch = ch; m_pmode = mode; m_pp = p; m_pd = d; m_pn = n;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] eb4, ed4;
        logic [2:0] eb3, ed3;
        for (int c = 0; c < 4; c++) begin eb4[c] = out_of(0, c); ed4[c] = e_done[0][c]; end
        for (int c = 0; c < 3; c++) begin eb3[c] = out_of(1, c); ed3[c] = e_done[1][c]; end
        check("blinky4", 32'(blk4), 32'(eb4));
        check("done4", 32'(done4), 32'(ed4));
        check("ready4", 32'(rdy4), 32'(!m_pend));
        check("blinky3", 32'(blk3), 32'(eb3));
        check("done3", 32'(done3), 32'(ed3));
        check("ready3", 32'(rdy3), 32'(!m_pend));
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge(cfg_valid_i, int'(cfg_ch_i), int'(cfg_mode_i), longint'(cfg_period_i),
                   longint'(cfg_duty_i), longint'(cfg_burst_i), en_i);
        #1;
        check_all();
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic send_cfg(input int ch, input int mode, input int p, input int d, input int n);
        bit acc, done;
        done = 1'b0;
        cfg_ch_i = 2'(ch); cfg_mode_i = 2'(mode);
        cfg_period_i = 8'(p); cfg_duty_i = 8'(d); cfg_burst_i = 8'(n);
        cfg_valid_i = 1'b1;
        for (int k = 0; k < 4 && !done; k++) begin
            acc = !m_pend;
            tick();
            if (acc) done = 1'b1;
        end
        cfg_valid_i = 1'b0;
        check("cfg_accept", 32'(done), 32'd1);
    endtask

    // Asynchronous assertion checked before any clock edge, then 2-cycle pulse.
    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        check("rst_blinky4", 32'(blk4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_ready4", 32'(rdy4), 32'd1);
        check("rst_blinky3", 32'(blk3), 32'd0);
        model_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        check_all();
    endtask

    initial begin
        bit pat32 [4];
        bit pat33 [10];
        bit rpat [5];
        int q_ch [3], q_mode [3], q_p [3], q_d [3];
        int idx;
        bit acc;
        pat32 = '{1, 1, 0, 0};
        pat33 = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        rpat  = '{1, 0, 1, 0, 1};

        #1;
        do_reset();
        ticks(2);

        // ch0 BLINK P=3 D=2: 1,1,0,0 from the apply edge
        send_cfg(0, 2, 3, 2, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("blink_p3d2", 32'(blk4[0]), 32'(pat32[i % 4]));
            tick();
        end

        // ch1 BURST P=1 D=1 N=3, done on the third wrap
        send_cfg(1, 3, 1, 1, 3);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("burst_blinky", 32'(blk4[1]), 32'(pat33[i]));
            check("burst_done", 32'(done4[1]), 32'(i == 6));
            tick();
        end

        // ch2 BLINK P=4 D=2 paused for 5 cycles mid-period
        send_cfg(2, 2, 4, 2, 0);
        ticks(3);
        en_i = 1'b0;
        ticks(5);
        en_i = 1'b1;
        ticks(10);

        // three configs back to back with valid held high; ch3 is dropped by the 3-channel unit
        q_ch = '{0, 3, 2}; q_mode = '{0, 2, 1}; q_p = '{0, 2, 0}; q_d = '{0, 1, 0};
        idx = 0;
        cfg_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cfg_ch_i = 2'(q_ch[idx]); cfg_mode_i = 2'(q_mode[idx]);
            cfg_period_i = 8'(q_p[idx]); cfg_duty_i = 8'(q_d[idx]); cfg_burst_i = 8'd0;
            check("ready_pattern", 32'(rdy4), 32'(rpat[k]));
            acc = !m_pend;
            tick();
            if (acc && idx < 2) idx++;
        end
        cfg_valid_i = 1'b0;
        ticks(6);

        // ch3 ON then reset; pending config and a running burst are discarded
        send_cfg(3, 1, 0, 0, 0);
        ticks(2);
        do_reset();
        ticks(2);
        send_cfg(1, 3, 3, 2, 2);
        ticks(3);
        send_cfg(0, 1, 0, 0, 0);
        do_reset();
        ticks(12);

        // duty extremes: D=0 always low, D>P always high
        send_cfg(0, 2, 3, 0, 0);
        send_cfg(1, 2, 3, 9, 0);
        ticks(9);
        check("duty_zero", 32'(blk4[0]), 32'd0);
        check("duty_over", 32'(blk4[1]), 32'd1);

        // BURST N=0 goes straight to done at the apply edge
        send_cfg(2, 3, 2, 1, 0);
        tick();
        check("burst_n0_done", 32'(done4[2]), 32'd1);
        ticks(3);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            en_i = ($urandom_range(0, 7) != 0);
            cfg_valid_i = ($urandom_range(0, 2) == 0);
            cfg_ch_i = 2'($urandom_range(0, 3));
            cfg_mode_i = 2'($urandom_range(0, 3));
            cfg_period_i = 8'($urandom_range(0, 6));
            cfg_duty_i = 8'($urandom_range(0, 8));
            cfg_burst_i = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) do_reset();
            else tick();
        end
        cfg_valid_i = 1'b0;
        ticks(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
